// File: rtl/i2c_pkg.sv
// Shared I2C definitions: state encoding and default target address,
// common to the initiator and the target receiver.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_DATA1     = 4'd3,
    ST_DATA1_ACK = 4'd4,
    ST_DATA2     = 4'd5,
    ST_DATA2_ACK = 4'd6,
    ST_IGNORE    = 4'd7
  } i2c_state_t;

  localparam logic [6:0] DEFAULT_TARGET_ADDR = 7'h1A;

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the clk domain and derives SCL edges plus
// START/STOP conditions from the synchronized copies only.
module i2c_bus_sync (
  input  logic clk,
  input  logic reset,
  input  logic i2c_sclk,
  input  logic i2c_sdat_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic r_scl_meta, r_scl_sync, r_scl_prev;
  logic r_sda_meta, r_sda_sync, r_sda_prev;

  // Flops come out of reset at 1 so an idle bus produces no spurious events.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_meta <= 1'b1;
      r_scl_sync <= 1'b1;
      r_scl_prev <= 1'b1;
      r_sda_meta <= 1'b1;
      r_sda_sync <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_meta <= i2c_sclk;
      r_scl_sync <= r_scl_meta;
      r_scl_prev <= r_scl_sync;
      r_sda_meta <= i2c_sdat_in;
      r_sda_sync <= r_sda_meta;
      r_sda_prev <= r_sda_sync;
    end
  end

  assign scl_rise  =  r_scl_sync & ~r_scl_prev;
  assign scl_fall  = ~r_scl_sync &  r_scl_prev;
  assign start_det =  r_scl_sync &  r_sda_prev & ~r_sda_sync;
  assign stop_det  =  r_scl_sync & ~r_sda_prev &  r_sda_sync;
  assign sda_s     =  r_sda_sync;

endmodule

// File: rtl/i2c_target_rx.sv
// Write-only I2C target: accepts address + two data bytes and presents
// a 7-bit register address with 9-bit data as a one-clk write strobe.
module i2c_target_rx
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = DEFAULT_TARGET_ADDR
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_sclk,
  input  logic       i2c_sdat_in,
  output logic       i2c_sdat_oe,
  output logic [6:0] wr_addr,
  output logic [8:0] wr_data,
  output logic       wr_valid,
  output logic       busy
);

  logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda_s;
  logic [7:0] w_byte;

  i2c_state_t r_state;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_byte1;
  logic       r_sdat_oe;
  logic [6:0] r_wr_addr;
  logic [8:0] r_wr_data;
  logic       r_wr_valid;

  i2c_bus_sync u_sync (
    .clk         (clk),
    .reset       (reset),
    .i2c_sclk    (i2c_sclk),
    .i2c_sdat_in (i2c_sdat_in),
    .scl_rise    (w_scl_rise),
    .scl_fall    (w_scl_fall),
    .start_det   (w_start),
    .stop_det    (w_stop),
    .sda_s       (w_sda_s)
  );

  assign w_byte = {r_shift[6:0], w_sda_s};

  // SDA is only ever changed on an SCL falling edge, so it stays stable while SCL is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'd0;
      r_byte1    <= 8'd0;
      r_sdat_oe  <= 1'b0;
      r_wr_addr  <= 7'd0;
      r_wr_data  <= 9'd0;
      r_wr_valid <= 1'b0;
    end else begin
      r_wr_valid <= 1'b0;
      if (w_start) begin
        r_state   <= ST_ADDR;
        r_bit_cnt <= 3'd7;
        r_shift   <= 8'd0;
        r_sdat_oe <= 1'b0;
      end else if (w_stop) begin
        r_state   <= ST_IDLE;
        r_sdat_oe <= 1'b0;
      end else begin
        case (r_state)
          ST_ADDR, ST_DATA1, ST_DATA2: begin
            if (w_scl_rise) begin
              r_shift <= w_byte;
              if (r_bit_cnt == 3'd0) begin
                r_bit_cnt <= 3'd7;
                case (r_state)
                  ST_ADDR:  r_state <= (w_byte == {TARGET_ADDR, 1'b0}) ? ST_ADDR_ACK : ST_IGNORE;
                  ST_DATA1: r_state <= ST_DATA1_ACK;
                  default: begin
                    r_state    <= ST_DATA2_ACK;
                    r_wr_addr  <= r_byte1[7:1];
                    r_wr_data  <= {r_byte1[0], w_byte};
                    r_wr_valid <= 1'b1;
                  end
                endcase
              end else begin
                r_bit_cnt <= r_bit_cnt - 3'd1;
              end
            end
          end
          // First falling edge pulls SDA low, the next one releases it and moves on.
          ST_ADDR_ACK, ST_DATA1_ACK, ST_DATA2_ACK: begin
            if (w_scl_fall) begin
              if (!r_sdat_oe) begin
                r_sdat_oe <= 1'b1;
                if (r_state == ST_DATA1_ACK) r_byte1 <= r_shift;
              end else begin
                r_sdat_oe <= 1'b0;
                case (r_state)
                  ST_ADDR_ACK:  r_state <= ST_DATA1;
                  ST_DATA1_ACK: r_state <= ST_DATA2;
                  default:      r_state <= ST_IGNORE;
                endcase
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign i2c_sdat_oe = r_sdat_oe;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign wr_valid    = r_wr_valid;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: bus-master tasks drive SCL/SDA, expected
// register writes go through a scoreboard queue checked on wr_valid.
module tb_i2c_target_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       i2c_sdat_oe;
  logic [6:0] wr_addr;
  logic [8:0] wr_data;
  logic       wr_valid;
  logic       busy;

  int nVec = 0;
  int nErr = 0;
  int validCount = 0;
  int oeRises = 0;
  logic prevValid = 1'b0;
  logic prevOe = 1'b0;
  logic [15:0] expQ[$];

  localparam time QTR = 40ns;

  always #5 clk = ~clk;

  // Open-drain bus: either side can pull SDA low.
  assign sda_line = i2c_sdat_oe ? 1'b0 : sda_m;

  i2c_target_rx #(.TARGET_ADDR(7'h1A)) dut (
    .clk         (clk),
    .reset       (reset),
    .i2c_sclk    (scl_m),
    .i2c_sdat_in (sda_line),
    .i2c_sdat_oe (i2c_sdat_oe),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .busy        (busy)
  );

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    logic [15:0] e;
    if (wr_valid) begin
      validCount++;
      nVec++;
      if (expQ.size() == 0) begin
        nErr++;
        $display("[TB] FAIL unexpected_wr_valid got addr=%h data=%h expected none", wr_addr, wr_data);
      end else begin
        e = expQ.pop_front();
        if ({wr_addr, wr_data} !== e)
          begin nErr++; $display("[TB] FAIL wr_write got addr=%h data=%h expected addr=%h data=%h",
                                 wr_addr, wr_data, e[15:9], e[8:0]); end
      end
      if (prevValid) begin
        nErr++;
        $display("[TB] FAIL wr_valid_width got 2+ cycles expected 1");
      end
    end
    if (i2c_sdat_oe && !prevOe) oeRises++;
    prevValid = wr_valid;
    prevOe = i2c_sdat_oe;
  end

  task automatic bus_start();
    sda_m = 1'b1; scl_m = 1'b1; #QTR;
    sda_m = 1'b0; #QTR;
    scl_m = 1'b0; #QTR;
  endtask

  task automatic bus_rstart();
    sda_m = 1'b1; #QTR;
    scl_m = 1'b1; #QTR;
    sda_m = 1'b0; #QTR;
    scl_m = 1'b0; #QTR;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #QTR;
    scl_m = 1'b1; #QTR;
    sda_m = 1'b1; #QTR;
    #(4*QTR);
  endtask

  task automatic bus_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; #QTR;
      scl_m = 1'b1; #(2*QTR);
      scl_m = 1'b0; #QTR;
    end
  endtask

  task automatic bus_byte(input logic [7:0] b, output logic ack);
    bus_bits(b);
    sda_m = 1'b1; #QTR;
    scl_m = 1'b1; #QTR;
    ack = ~sda_line;
    #QTR;
    scl_m = 1'b0; #QTR;
  endtask

  task automatic applyStimulus3(input logic [7:0] b0, b1, b2, output logic [2:0] acks);
    logic a;
    bus_start();
    bus_byte(b0, a); acks[2] = a;
    bus_byte(b1, a); acks[1] = a;
    bus_byte(b2, a); acks[0] = a;
    bus_stop();
  endtask

  task automatic test_reset();
    @(posedge clk); #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nVec++;
    if ({i2c_sdat_oe, wr_valid, busy, wr_addr, wr_data} !== 19'd0) begin
      nErr++;
      $display("[TB] FAIL reset_outputs got oe=%b v=%b busy=%b addr=%h data=%h expected all 0",
               i2c_sdat_oe, wr_valid, busy, wr_addr, wr_data);
    end
    reset = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_basic_write();
    logic [2:0] acks;
    int v0 = validCount;
    expQ.push_back({7'h0F, 9'h000});
    applyStimulus3(8'h34, 8'h1E, 8'h00, acks);
    nVec++;
    if (acks !== 3'b111) begin nErr++; $display("[TB] FAIL basic_acks got %b expected 111", acks); end
    nVec++;
    if (validCount - v0 !== 1) begin nErr++; $display("[TB] FAIL basic_valid_count got %0d expected 1", validCount - v0); end
    nVec++;
    if (busy !== 1'b0) begin nErr++; $display("[TB] FAIL basic_busy_after_stop got %b expected 0", busy); end
  endtask

  task automatic test_ignored(input logic [7:0] addrByte);
    logic [2:0] acks;
    int v0 = validCount;
    int o0 = oeRises;
    applyStimulus3(addrByte, 8'h12, 8'h01, acks);
    nVec++;
    if (acks !== 3'b000) begin nErr++; $display("[TB] FAIL ignore_%h_acks got %b expected 000", addrByte, acks); end
    nVec++;
    if (oeRises !== o0) begin nErr++; $display("[TB] FAIL ignore_%h_sda_driven got %0d expected 0", addrByte, oeRises - o0); end
    nVec++;
    if (validCount !== v0 || busy !== 1'b0) begin
      nErr++;
      $display("[TB] FAIL ignore_%h_idle got valids=%0d busy=%b expected 0/0", addrByte, validCount - v0, busy);
    end
  endtask

  task automatic test_partial();
    logic a0, a1;
    int v0 = validCount;
    bus_start();
    bus_byte(8'h34, a0);
    bus_byte(8'h1E, a1);
    bus_stop();
    nVec++;
    if ({a0, a1} !== 2'b11) begin nErr++; $display("[TB] FAIL partial_acks got %b%b expected 11", a0, a1); end
    nVec++;
    if (validCount !== v0 || busy !== 1'b0) begin
      nErr++;
      $display("[TB] FAIL partial_idle got valids=%0d busy=%b expected 0/0", validCount - v0, busy);
    end
    nVec++;
    if ({wr_addr, wr_data} !== {7'h0F, 9'h000}) begin
      nErr++;
      $display("[TB] FAIL partial_hold got addr=%h data=%h expected 0f/000", wr_addr, wr_data);
    end
  endtask

  task automatic test_back_to_back();
    logic a0, a1, a2, a3, a4;
    int v0 = validCount;
    expQ.push_back({7'h09, 9'h001});
    bus_start();
    bus_byte(8'h34, a0);
    bus_byte(8'h0D, a1);
    bus_rstart();
    bus_byte(8'h34, a2);
    bus_byte(8'h12, a3);
    bus_byte(8'h01, a4);
    bus_stop();
    nVec++;
    if ({a0, a1, a2, a3, a4} !== 5'b11111) begin
      nErr++;
      $display("[TB] FAIL rstart_acks got %b expected 11111", {a0, a1, a2, a3, a4});
    end
    nVec++;
    if (validCount - v0 !== 1) begin nErr++; $display("[TB] FAIL rstart_valid_count got %0d expected 1", validCount - v0); end
  endtask

  task automatic test_reset_during_ack();
    logic [2:0] acks;
    int v0;
    int n = 0;
    bus_start();
    bus_bits(8'h34);
    sda_m = 1'b1;
    while (!i2c_sdat_oe && n < 32) begin @(posedge clk); n++; end
    nVec++;
    if (i2c_sdat_oe !== 1'b1) begin nErr++; $display("[TB] FAIL rst_ack_wait got oe=%b expected 1 (timeout)", i2c_sdat_oe); end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    nVec++;
    if ({i2c_sdat_oe, busy} !== 2'b00) begin
      nErr++;
      $display("[TB] FAIL rst_release got oe=%b busy=%b expected 0/0", i2c_sdat_oe, busy);
    end
    reset = 1'b0;
    #QTR; scl_m = 1'b1; #(2*QTR); scl_m = 1'b0; #QTR;
    bus_stop();
    nVec++;
    if (busy !== 1'b0) begin nErr++; $display("[TB] FAIL rst_idle got busy=%b expected 0", busy); end
    v0 = validCount;
    expQ.push_back({7'h0F, 9'h000});
    applyStimulus3(8'h34, 8'h1E, 8'h00, acks);
    nVec++;
    if (acks !== 3'b111 || validCount - v0 !== 1) begin
      nErr++;
      $display("[TB] FAIL rst_rewrite got acks=%b valids=%0d expected 111/1", acks, validCount - v0);
    end
  endtask

  task automatic checkOutput();
    nVec++;
    if (expQ.size() !== 0) begin
      nErr++;
      $display("[TB] FAIL missing_writes got %0d pending expected 0", expQ.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_ignored(8'h36);
    test_ignored(8'h35);
    test_partial();
    test_back_to_back();
    test_reset_during_ack();
    repeat (10) @(posedge clk);
    checkOutput();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/i2c_target_rx.md
I2C_TARGET_RX -- requirements
Module: i2c_target_rx

Interface
REQ-001 SHALL have parameter TARGET_ADDR, default 7'h1A, meaning the 7-bit I2C address this target answers (address byte 8'h34 with write bit).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; it must be at least 8x the SCL rate.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port i2c_sclk, input, 1 bit: the bus SCL, asynchronous to clk.
REQ-005 SHALL have port i2c_sdat_in, input, 1 bit: the bus SDA read-back, asynchronous to clk.
REQ-006 SHALL have port i2c_sdat_oe, output, 1 bit: when 1, the top level drives SDA low; when 0, SDA is released (Z).
REQ-007 SHALL have port wr_addr, output, 7 bits: register address, taken from data byte 1 [7:1].
REQ-008 SHALL have port wr_data, output, 9 bits: register data, {byte1[0], byte2[7:0]}.
REQ-009 SHALL have port wr_valid, output, 1 bit: one-clk pulse when wr_addr/wr_data are valid.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-011 SHALL synchronize SCL and SDA through 2 flip-flops each, then register the synchronized values once more for edge detection; all decisions use synchronized signals only.
REQ-012 SHALL detect START as synchronized SDA 1->0 while SCL=1, and STOP as SDA 0->1 while SCL=1.
REQ-013 SHALL sample a data bit on a synchronized SCL rising edge, MSB first, into an 8-bit shift register; the bit counter runs 7 down to 0.
REQ-014 SHALL implement the states IDLE, ADDR, ADDR_ACK, DATA1, DATA1_ACK, DATA2, DATA2_ACK and IGNORE.
REQ-015 SHALL go from any state to ADDR on START, including a repeated START, clearing the bit counter and releasing i2c_sdat_oe.
REQ-016 SHALL go from any state to IDLE on STOP, with i2c_sdat_oe=0; a partial transfer is discarded and wr_valid is not asserted.
REQ-017 After 8 address bits, on a match with TARGET_ADDR and R/W=0, SHALL enter ADDR_ACK; otherwise (mismatch or R/W=1) SHALL enter IGNORE with no ACK.
REQ-018 ACK timing: SHALL assert i2c_sdat_oe on the first SCL falling edge after bit 0 of an acknowledged byte, and deassert it on the next SCL falling edge. That is exactly one SCL period (the 9th clock), then move to the next data state.
REQ-019 SHALL ACK after DATA1 and DATA2; DATA2_ACK then moves to IGNORE.
REQ-020 In IGNORE, SHALL never drive SDA: further bytes get NACK and it waits for STOP or START.
REQ-021 SHALL pulse wr_valid for exactly one clk, on the clk after DATA2 bit 0 is sampled, with wr_addr/wr_data updated in that same cycle.
REQ-022 wr_addr and wr_data SHALL hold their value until the next wr_valid.
REQ-023 SHALL never change i2c_sdat_oe while synchronized SCL=1, except that reset or STOP forces it to 0.
REQ-024 If START and an SCL edge are detected in the same clk, START SHALL have priority.

Reset
REQ-025 On a clk edge with reset=1, SHALL set state IDLE, i2c_sdat_oe=0, wr_valid=0, busy=0, wr_addr=0, wr_data=0, shift register and counter to 0, and all synchronizer flops to 1 (idle bus).
REQ-026 Reset mid-transfer SHALL release SDA within that clk edge; after reset the block stays IDLE until a new START is seen.

Structure
REQ-027 SHALL place the state encoding (4-bit state constants) and default TARGET_ADDR in the shared package i2c_pkg, which the existing I2C initiator also uses.
REQ-028 SHALL use one sub-module, i2c_bus_sync: the 2-FF synchronizers plus edge and START/STOP detection, with outputs scl_rise, scl_fall, start_det, stop_det, sda_s.
REQ-029 SHALL keep the FSM, shift register, counter and output registers in i2c_target_rx.

Verification
REQ-030 Write 8'h34, 8'h1E, 8'h00, then STOP: SHALL give 3 ACKs, one wr_valid with wr_addr=7'h0F and wr_data=9'h000, and busy low after STOP.
REQ-031 Address byte 8'h36: SDA SHALL never be driven, wr_valid=0, and state IDLE after STOP.
REQ-032 Address byte 8'h35 (read): SHALL NACK, with no further SDA drive until STOP.
REQ-033 Write 8'h34, 8'h1E, STOP before byte 2: SHALL give 2 ACKs, wr_valid=0, busy=0.
REQ-034 Write 8'h34, 8'h0D, then repeated START, 8'h34, 8'h12, 8'h01, STOP: SHALL give exactly one wr_valid, with wr_addr=7'h09 and wr_data=9'h001.
REQ-035 Assert reset while i2c_sdat_oe=1 during an ACK: i2c_sdat_oe=0 at the next clk, then IDLE; a subsequent full write succeeds.
